scoreboard_hazard: RTL and testbench

- Producer-side hazard unit, counterpart to the bypass network.
- Tracks in-flight register writes whose data is not yet forwardable (loads, multi-cycle divides) and stalls decode on RAW, WAW and structural conflicts.
- Sits between decode/issue and EX/MEM, fed by load-return and divider-done events.
- Once a write becomes forwardable, the bypass path supplies the data.

---
 rtl/scoreboard_hazard_pkg.sv | 24 ++
 rtl/scoreboard_hazard_scb_load_cnt.sv | 38 +++
 rtl/scoreboard_hazard.sv | 126 ++++++++++++
 tb/tb_scoreboard_hazard.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_hazard_pkg.sv
// Shared definitions for the producer-side hazard scoreboard: datapath
// width, register-file geometry and the hazard-cause encoding.
`ifndef SCOREBOARD_HAZARD_DEFS
`define SCOREBOARD_HAZARD_DEFS
`define XLEN 32
`endif

package scoreboard_hazard_pkg;

   localparam int XLEN       = `XLEN;
   localparam int REG_ADDR_W = 5;
   localparam int NREG       = 32;
   localparam int LOAD_CNT_W = 3;

   // Highest-priority cause wins when several hazards coincide
   typedef enum logic [2:0] {
      HZ_NONE    = 3'd0,
      HZ_RAW     = 3'd1,
      HZ_WAW     = 3'd2,
      HZ_LDFULL  = 3'd3,
      HZ_DIVBUSY = 3'd4
   } hz_cause_e;

endpackage

// File: rtl/scoreboard_hazard_scb_load_cnt.sv
// Outstanding-load counter: saturating up/down count with a full flag.
// A decrement at zero is dropped, so late returns after reset cannot wrap.
module scb_load_cnt #(
   parameter int MAX_LOADS = 2,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             full
);

   logic [CNT_W-1:0] cnt_q;
   logic             dec_eff;
   logic             inc_eff;

   assign full    = (cnt_q == CNT_W'(MAX_LOADS));
   assign dec_eff = dec && (cnt_q != '0);
   // Issue logic already stalls a load at full; the guard keeps the count bounded regardless
   assign inc_eff = inc && (!full || dec_eff);
   assign cnt     = cnt_q;

   // Up/down count; simultaneous inc and dec leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         case ({inc_eff, dec_eff})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/scoreboard_hazard.sv
// Producer-side hazard scoreboard. Tracks register writes from loads and
// divides that are not yet forwardable and stalls decode on RAW, WAW,
// load-queue-full and divider-busy conflicts. A done event releases the
// stall in its own cycle; the bypass network supplies the data.
// Optional build macro SCB_PERF_EN adds stall_cycles_o and raw_stall_o.
module scoreboard_hazard #(
   parameter int MAX_LOADS = 2,
   parameter int NREG      = scoreboard_hazard_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid_i,
   input  logic [4:0]      id_rs1_addr_i,
   input  logic            id_rs1_re_i,
   input  logic [4:0]      id_rs2_addr_i,
   input  logic            id_rs2_re_i,
   input  logic [4:0]      id_rd_addr_i,
   input  logic            id_rdwe_i,
   input  logic            id_is_load_i,
   input  logic            id_is_div_i,
   input  logic            flush_i,
   input  logic            load_done_i,
   input  logic [4:0]      load_rd_i,
   input  logic            div_done_i,
   input  logic [4:0]      div_rd_i,
   output logic            stall_o,
   output logic            div_busy_o,
   output logic [NREG-1:0] pending_o,
   output logic [2:0]      load_cnt_o
`ifdef SCB_PERF_EN
   ,
   output logic [31:0]     stall_cycles_o,
   output logic            raw_stall_o
`endif
);

   import scoreboard_hazard_pkg::*;

   logic [NREG-1:0]       pending_q;
   logic [NREG-1:0]       clr;
   logic [NREG-1:0]       set;
   logic                  div_busy_q;
   logic                  issue;
   logic                  tracked;
   logic                  load_full;
   logic [LOAD_CNT_W-1:0] load_cnt;
   hz_cause_e             cause;

   assign issue   = id_valid_i && !stall_o && !flush_i;
   assign tracked = issue && id_rdwe_i && (id_rd_addr_i != '0) &&
                    (id_is_load_i || id_is_div_i);

   // One-hot clear (done events) and set (tracked issue) vectors; x0 never tracked
   always_comb begin
      clr = '0;
      set = '0;
      for (int i = 1; i < NREG; i++) begin
         if (load_done_i && (load_rd_i == REG_ADDR_W'(i)))   clr[i] = 1'b1;
         if (div_done_i  && (div_rd_i  == REG_ADDR_W'(i)))   clr[i] = 1'b1;
         if (tracked     && (id_rd_addr_i == REG_ADDR_W'(i))) set[i] = 1'b1;
      end
   end

   // Hazard classification; a bit cleared this cycle no longer blocks
   always_comb begin
      cause = HZ_NONE;
      if (id_valid_i) begin
         if ((id_rs1_re_i && pending_q[id_rs1_addr_i] && !clr[id_rs1_addr_i]) ||
             (id_rs2_re_i && pending_q[id_rs2_addr_i] && !clr[id_rs2_addr_i]))
            cause = HZ_RAW;
         else if (id_rdwe_i && (id_rd_addr_i != '0) &&
                  pending_q[id_rd_addr_i] && !clr[id_rd_addr_i])
            cause = HZ_WAW;
         else if (id_is_load_i && load_full && !load_done_i)
            cause = HZ_LDFULL;
         else if (id_is_div_i && div_busy_q && !div_done_i)
            cause = HZ_DIVBUSY;
      end
   end

   assign stall_o = (cause != HZ_NONE);

   // Pending bits: set beats clear on the same register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending_q <= '0;
      else        pending_q <= (pending_q & ~clr) | set;
   end

   // Divider occupancy: a new divide issued alongside a completion keeps it busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        div_busy_q <= 1'b0;
      else if (issue && id_is_div_i)     div_busy_q <= 1'b1;
      else if (div_done_i)               div_busy_q <= 1'b0;
   end

   // Only loads that own a pending bit are counted, so every return has a matching entry
   scb_load_cnt #(
      .MAX_LOADS (MAX_LOADS),
      .CNT_W     (LOAD_CNT_W)
   ) u_load_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (tracked && id_is_load_i),
      .dec   (load_done_i),
      .cnt   (load_cnt),
      .full  (load_full)
   );

   assign pending_o  = pending_q;
   assign div_busy_o = div_busy_q;
   assign load_cnt_o = load_cnt;

`ifdef SCB_PERF_EN
   logic [31:0] stall_cycles_q;

   // Free-running stall-cycle count, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       stall_cycles_q <= '0;
      else if (stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
   end

   assign stall_cycles_o = stall_cycles_q;
   assign raw_stall_o    = (cause == HZ_RAW);
`endif

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Self-checking bench for scoreboard_hazard: a vector table of decode and
// done-event stimulus with hand-derived expected stall and next-state
// values, followed by an asynchronous reset sequence mid-stall.
module tb_scoreboard_hazard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid_i;
   logic [4:0]  id_rs1_addr_i;
   logic        id_rs1_re_i;
   logic [4:0]  id_rs2_addr_i;
   logic        id_rs2_re_i;
   logic [4:0]  id_rd_addr_i;
   logic        id_rdwe_i;
   logic        id_is_load_i;
   logic        id_is_div_i;
   logic        flush_i;
   logic        load_done_i;
   logic [4:0]  load_rd_i;
   logic        div_done_i;
   logic [4:0]  div_rd_i;
   logic        stall_o;
   logic        div_busy_o;
   logic [31:0] pending_o;
   logic [2:0]  load_cnt_o;
`ifdef SCB_PERF_EN
   logic [31:0] stall_cycles_o;
   logic        raw_stall_o;
`endif

   scoreboard_hazard #(.MAX_LOADS(2), .NREG(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid_i    (id_valid_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs1_re_i   (id_rs1_re_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rs2_re_i   (id_rs2_re_i),
      .id_rd_addr_i  (id_rd_addr_i),
      .id_rdwe_i     (id_rdwe_i),
      .id_is_load_i  (id_is_load_i),
      .id_is_div_i   (id_is_div_i),
      .flush_i       (flush_i),
      .load_done_i   (load_done_i),
      .load_rd_i     (load_rd_i),
      .div_done_i    (div_done_i),
      .div_rd_i      (div_rd_i),
      .stall_o       (stall_o),
      .div_busy_o    (div_busy_o),
      .pending_o     (pending_o),
      .load_cnt_o    (load_cnt_o)
`ifdef SCB_PERF_EN
      ,
      .stall_cycles_o(stall_cycles_o),
      .raw_stall_o   (raw_stall_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [4:0]  rs1;
      logic        re1;
      logic [4:0]  rs2;
      logic        re2;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic        dv;
      logic        fl;
      logic        ldd;
      logic [4:0]  ldrd;
      logic        dvd;
      logic [4:0]  dvrd;
      logic        e_stall;
      logic [31:0] e_pend;
      logic [2:0]  e_cnt;
      logic        e_busy;
   } vec_t;

   typedef struct {
      logic [31:0] pend;
      logic [2:0]  cnt;
      logic        busy;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [31:0] b(input int n);
      logic [31:0] one;
      one = 32'd1;
      return one << n;
   endfunction

   function automatic vec_t mk(
      input logic valid, input logic [4:0] rs1, input logic re1,
      input logic [4:0] rs2, input logic re2, input logic [4:0] rd,
      input logic we, input logic ld, input logic dv, input logic fl,
      input logic ldd, input logic [4:0] ldrd, input logic dvd, input logic [4:0] dvrd,
      input logic e_stall, input logic [31:0] e_pend, input logic [2:0] e_cnt,
      input logic e_busy);
      vec_t v;
      v.valid = valid; v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2;
      v.rd = rd; v.we = we; v.ld = ld; v.dv = dv; v.fl = fl;
      v.ldd = ldd; v.ldrd = ldrd; v.dvd = dvd; v.dvrd = dvrd;
      v.e_stall = e_stall; v.e_pend = e_pend; v.e_cnt = e_cnt; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      id_valid_i    = v.valid;
      id_rs1_addr_i = v.rs1;
      id_rs1_re_i   = v.re1;
      id_rs2_addr_i = v.rs2;
      id_rs2_re_i   = v.re2;
      id_rd_addr_i  = v.rd;
      id_rdwe_i     = v.we;
      id_is_load_i  = v.ld;
      id_is_div_i   = v.dv;
      flush_i       = v.fl;
      load_done_i   = v.ldd;
      load_rd_i     = v.ldrd;
      div_done_i    = v.dvd;
      div_rd_i      = v.dvrd;
   endtask

   task automatic pop_and_compare(input int idx);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard_empty at step %0d: got empty queue required one entry", idx);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("pending[%0d]", idx),  pending_o,  e.pend);
         check($sformatf("load_cnt[%0d]", idx), {29'd0, load_cnt_o}, {29'd0, e.cnt});
         check($sformatf("div_busy[%0d]", idx), {31'd0, div_busy_o}, {31'd0, e.busy});
      end
   endtask

   initial begin
      exp_t e;
      vec_t idle;

      // valid rs1 r1 rs2 r2 rd we ld dv fl | ldd ldrd dvd dvrd | stall pend cnt busy
      // load x5, then add x6,x5,x1 waits for the return of x5
      vecs.push_back(mk(1, 0,0, 0,0,  5,1,1,0,0, 0, 0,0, 0, 0, b(5), 1,0));
      vecs.push_back(mk(1, 5,1, 1,1,  6,1,0,0,0, 0, 0,0, 0, 1, b(5), 1,0));
      vecs.push_back(mk(1, 5,1, 1,1,  6,1,0,0,0, 0, 0,0, 0, 1, b(5), 1,0));
      vecs.push_back(mk(1, 5,1, 1,1,  6,1,0,0,0, 1, 5,0, 0, 0, 32'd0, 0,0));
      // div x7, div x8 blocked until x7 completes, then add x9,x7,x0
      vecs.push_back(mk(1, 1,1, 2,1,  7,1,0,1,0, 0, 0,0, 0, 0, b(7), 0,1));
      vecs.push_back(mk(1, 3,1, 4,1,  8,1,0,1,0, 0, 0,0, 0, 1, b(7), 0,1));
      vecs.push_back(mk(1, 3,1, 4,1,  8,1,0,1,0, 0, 0,1, 7, 0, b(8), 0,1));
      vecs.push_back(mk(1, 7,1, 0,1,  9,1,0,0,0, 0, 0,0, 0, 0, b(8), 0,1));
      vecs.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 0, 0,1, 8, 0, 32'd0, 0,0));
      // three loads against a limit of two
      vecs.push_back(mk(1, 0,0, 0,0, 10,1,1,0,0, 0, 0,0, 0, 0, b(10), 1,0));
      vecs.push_back(mk(1, 0,0, 0,0, 11,1,1,0,0, 0, 0,0, 0, 0, b(10)|b(11), 2,0));
      vecs.push_back(mk(1, 0,0, 0,0, 12,1,1,0,0, 0, 0,0, 0, 1, b(10)|b(11), 2,0));
      vecs.push_back(mk(1, 0,0, 0,0, 12,1,1,0,0, 1,10,0, 0, 0, b(11)|b(12), 2,0));
      vecs.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 1,11,0, 0, 0, b(12), 1,0));
      vecs.push_back(mk(0, 0,0, 0,0,  0,0,0,0,0, 1,12,0, 0, 0, 32'd0, 0,0));
      // load to x0, then a flushed load to x3
      vecs.push_back(mk(1, 0,0, 0,0,  0,1,1,0,0, 0, 0,0, 0, 0, 32'd0, 0,0));
      vecs.push_back(mk(1, 0,0, 0,0,  3,1,1,0,1, 0, 0,0, 0, 0, 32'd0, 0,0));
      // WAW on x13, released by its own return
      vecs.push_back(mk(1, 0,0, 0,0, 13,1,1,0,0, 0, 0,0, 0, 0, b(13), 1,0));
      vecs.push_back(mk(1, 0,0, 0,0, 13,1,0,0,0, 0, 0,0, 0, 1, b(13), 1,0));
      vecs.push_back(mk(1, 0,0, 0,0, 13,1,0,0,0, 1,13,0, 0, 0, 32'd0, 0,0));
      // set/clear race on x4, then a divide and a stalled consumer of x4
      vecs.push_back(mk(1, 0,0, 0,0,  4,1,1,0,0, 0, 0,0, 0, 0, b(4), 1,0));
      vecs.push_back(mk(1, 0,0, 0,0,  4,1,1,0,0, 1, 4,0, 0, 0, b(4), 1,0));
      vecs.push_back(mk(1, 1,1, 2,1, 14,1,0,1,0, 0, 0,0, 0, 0, b(4)|b(14), 1,1));
      vecs.push_back(mk(1, 1,1, 4,1, 15,1,0,0,0, 0, 0,0, 0, 1, b(4)|b(14), 1,1));

      idle = mk(0, 0,0, 0,0, 0,0,0,0,0, 0, 0,0, 0, 0, 32'd0, 0,0);
      drive(idle);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pending",  pending_o, 32'd0);
      check("reset_load_cnt", {29'd0, load_cnt_o}, 32'd0);
      check("reset_div_busy", {31'd0, div_busy_o}, 32'd0);
      check("reset_stall",    {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("stall[%0d]", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
         e.pend = vecs[i].e_pend;
         e.cnt  = vecs[i].e_cnt;
         e.busy = vecs[i].e_busy;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         pop_and_compare(i);
      end

      // Asynchronous reset while the last vector is still stalling
      @(negedge clk);
      check("pre_reset_stall", {31'd0, stall_o}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_pending",  pending_o, 32'd0);
      check("async_load_cnt", {29'd0, load_cnt_o}, 32'd0);
      check("async_div_busy", {31'd0, div_busy_o}, 32'd0);
      check("async_stall",    {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Late done events for entries wiped by the reset must not underflow
      drive(mk(0, 0,0, 0,0, 0,0,0,0,0, 1, 4,1,14, 0, 32'd0, 0,0));
      #1;
      check("late_done_stall", {31'd0, stall_o}, 32'd0);
      e.pend = 32'd0;
      e.cnt  = 3'd0;
      e.busy = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_and_compare(vecs.size());
      @(negedge clk);
      drive(idle);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
